vid_timing_gen: RTL and testbench
=================================

Name: vid_timing_gen

Overview:
- Sits directly downstream of the 16→63 MHz PLL.
- Runs on the PLL output clock and consumes the PLL lock indicator, so the video domain starts only after lock is stable.
- Generates the pixel-enable strobe, horizontal/vertical counters, sync pulses and active-area flag for the display pipeline.
- Halts and restarts cleanly on loss of lock.

Parameters:
- PIX_DIV, 1: clock cycles per pixel (≥1).
- LOCK_WAIT, 1024: consecutive synchronized-lock cycles required before running (≥1).
- H_ACTIVE, 1024 / H_FP, 24 / H_SYNC, 136 / H_BP, 160: horizontal timing in pixels.
- V_ACTIVE, 768 / V_FP, 3 / V_SYNC, 6 / V_BP, 29: vertical timing in lines.
- HS_POL, 0 / VS_POL, 0: sync asserted level.
- X_W, 11 / Y_W, 10: counter widths; each must hold its total minus 1.

Ports:
- clock  in  1  PLL output clock; single clock domain.
- reset_n  in  1  synchronous, active-low reset.
- pll_locked  in  1  PLL lock; asynchronous to this domain.
- run  out  1  timing generator running.
- pix_en  out  1  one-clock pixel strobe.
- hsync  out  1  horizontal sync at HS_POL when asserted.
- vsync  out  1  vertical sync at VS_POL when asserted.
- active  out  1  pixel inside the visible area.
- x  out  X_W  horizontal count.
- y  out  Y_W  vertical count.
- line_start  out  1  pulse on the first clock of each line.
- frame_start  out  1  pulse on the first clock of each frame.

Behaviour:
- Definitions: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*.
- Reset (reset_n=0 at a clock edge): all counters 0; run=0, pix_en=0, active=0, x=0, y=0, line_start=0, frame_start=0; hsync=!HS_POL, vsync=!VS_POL. Reset overrides every other event in the same cycle.
- Lock qualification:
  - pll_locked passes through a 2-flop synchronizer (lk_s).
  - Lock counter increments while lk_s=1 and saturates at LOCK_WAIT.
  - Any lk_s=0 clears the lock counter.
  - run rises on the clock the counter reaches LOCK_WAIT.
  - run falls on the first clock lk_s=0 is seen (3 clocks after pll_locked falls).
- State machine:
  - WAIT_LOCK: counting, outputs idle → RUN when the lock counter reaches LOCK_WAIT.
  - RUN: from any RUN cycle → WAIT_LOCK when lk_s=0.
  - Entering WAIT_LOCK clears the divider, x and y, and forces outputs to their reset values.
- Pixel divider:
  - Counts 0..PIX_DIV-1 in RUN.
  - pix_en=1 when divider = PIX_DIV-1; with PIX_DIV=1, pix_en=1 on every RUN cycle.
  - The first RUN cycle has divider=0, x=0, y=0.
- Counters (advance only on the clock after a pix_en cycle):
  - x wraps from H_TOTAL-1 to 0.
  - y increments only on x wrap and wraps from V_TOTAL-1 to 0.
- Outputs are registered and consistent with the x,y held in the same cycle:
  - active = (x<H_ACTIVE) && (y<V_ACTIVE).
  - hsync asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) for whole lines.
  - line_start=1 only on the first clock x=0 (divider=0), including the first RUN cycle.
  - frame_start likewise, but only when y=0 as well.
- Every clock cycle is valid; there is no backpressure.

Optional Feature:
- Macro: VID_TIMING_GEN_BORDER_EN.
- When defined:
  - Adds parameters BORDER_H (default 0) and BORDER_V (default 0).
  - Adds output border (1 bit, reset 0).
  - border=1 when active=1 and x is within BORDER_H of either horizontal active edge, or y is within BORDER_V of either vertical active edge.
  - In that region the active output is cleared, so the visible picture is a centered inner region.
- When undefined: no border port, and active is as specified above.

Test Plan (PIX_DIV=2, LOCK_WAIT=4, H 8/2/2/2 → H_TOTAL=14, V 4/1/1/1 → V_TOTAL=7):
1. Lock startup: pll_locked=1 held; release reset_n → run=1 on the 6th clock; frame_start=1 and line_start=1 on that clock; x=0, y=0; pix_en on the 2nd RUN clock.
2. Line timing: hsync asserted during x=10,11 (4 clocks), then deasserted; line_start period 28 clocks; active=1 exactly for x 0..7 while y<4.
3. Frame timing: vsync asserted for all of y=5 (28 clocks); frame_start period 196 clocks; y wraps 6→0 at the same edge x wraps 13→0.
4. Glitchy lock: pll_locked high for 3 clocks, low 1, high 3 → run stays 0 and outputs stay at reset values.
5. Lock loss mid-frame (x=5, y=2): pll_locked falls → run=0 3 clocks later and all outputs idle; pll_locked restored → run returns 6 clocks later with frame_start=1 at x=0, y=0.
6. Reset mid-line while running: reset_n=0 for 1 clock → next cycle all outputs at reset values; after release, the startup sequence repeats as in scenario 1.

Source files
------------

// File: rtl/vid_timing_gen.sv
// Video timing generator: lock-qualified start, pixel divider, h/v counters, sync/active flags.
// Optional border band (macro VID_TIMING_GEN_BORDER_EN) carves a frame out of the active area.
module vid_timing_gen #(
    parameter int PIX_DIV   = 1,
    parameter int LOCK_WAIT = 1024,
    parameter int H_ACTIVE  = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_ACTIVE  = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int X_W       = 11,
    parameter int Y_W       = 10
`ifdef VID_TIMING_GEN_BORDER_EN
    ,
    parameter int BORDER_H  = 0,
    parameter int BORDER_V  = 0
`endif
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           pll_locked,
    output logic           run,
    output logic           pix_en,
    output logic           hsync,
    output logic           vsync,
    output logic           active,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           line_start,
    output logic           frame_start
`ifdef VID_TIMING_GEN_BORDER_EN
    ,
    output logic           border
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CW      = $clog2(LOCK_WAIT + 1);
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [CW-1:0]  CNT_MAX = CW'(LOCK_WAIT);
    localparam logic [DW-1:0]  DIV_MAX = DW'(PIX_DIV - 1);
    localparam logic [X_W-1:0] X_MAX   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_MAX   = Y_W'(V_TOTAL - 1);
    localparam logic           HS_ON   = (HS_POL != 0);
    localparam logic           VS_ON   = (VS_POL != 0);

    typedef enum logic {WAIT_LOCK, RUN} state_t;

    state_t         state, state_n;
    logic           lk_m, lk_s;
    logic [CW-1:0]  lock_cnt, cnt_n;
    logic [DW-1:0]  div, div_n;
    logic [X_W-1:0] x_n;
    logic [Y_W-1:0] y_n;
    logic           go, hs_in, vs_in, act_in;
    int             xi, yi;
`ifdef VID_TIMING_GEN_BORDER_EN
    logic           brd_in;
`endif

    // Outputs are registered from the next-state x/y so flags always match the counters they sit beside.
    always_comb begin
        cnt_n   = lk_s ? ((lock_cnt == CNT_MAX) ? lock_cnt : lock_cnt + 1'b1) : '0;
        state_n = state;
        div_n   = div;
        x_n     = x;
        y_n     = y;
        case (state)
            WAIT_LOCK: begin
                if (cnt_n == CNT_MAX) begin
                    state_n = RUN;
                    div_n   = '0;
                    x_n     = '0;
                    y_n     = '0;
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_n = WAIT_LOCK;
                    div_n   = '0;
                    x_n     = '0;
                    y_n     = '0;
                end else if (div == DIV_MAX) begin
                    div_n = '0;
                    if (x == X_MAX) begin
                        x_n = '0;
                        y_n = (y == Y_MAX) ? '0 : y + 1'b1;
                    end else begin
                        x_n = x + 1'b1;
                    end
                end else begin
                    div_n = div + 1'b1;
                end
            end
            default: state_n = WAIT_LOCK;
        endcase

        go     = (state_n == RUN);
        xi     = int'(x_n);
        yi     = int'(y_n);
        act_in = (xi < H_ACTIVE) && (yi < V_ACTIVE);
        hs_in  = (xi >= H_ACTIVE + H_FP) && (xi < H_ACTIVE + H_FP + H_SYNC);
        vs_in  = (yi >= V_ACTIVE + V_FP) && (yi < V_ACTIVE + V_FP + V_SYNC);
`ifdef VID_TIMING_GEN_BORDER_EN
        brd_in = act_in && ((xi < BORDER_H) || (xi >= H_ACTIVE - BORDER_H) ||
                            (yi < BORDER_V) || (yi >= V_ACTIVE - BORDER_V));
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lk_m        <= 1'b0;
            lk_s        <= 1'b0;
            lock_cnt    <= '0;
            state       <= WAIT_LOCK;
            div         <= '0;
            x           <= '0;
            y           <= '0;
            run         <= 1'b0;
            pix_en      <= 1'b0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
`ifdef VID_TIMING_GEN_BORDER_EN
            border      <= 1'b0;
`endif
        end else begin
            lk_m        <= pll_locked;
            lk_s        <= lk_m;
            lock_cnt    <= cnt_n;
            state       <= state_n;
            div         <= div_n;
            x           <= x_n;
            y           <= y_n;
            run         <= go;
            pix_en      <= go && (div_n == DIV_MAX);
            hsync       <= (go && hs_in) ? HS_ON : ~HS_ON;
            vsync       <= (go && vs_in) ? VS_ON : ~VS_ON;
            line_start  <= go && (div_n == '0) && (x_n == '0);
            frame_start <= go && (div_n == '0) && (x_n == '0) && (y_n == '0);
`ifdef VID_TIMING_GEN_BORDER_EN
            active      <= go && act_in && !brd_in;
            border      <= go && brd_in;
`else
            active      <= go && act_in;
`endif
        end
    end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Self-checking bench for vid_timing_gen: directed timing scenarios plus random lock/reset
// stimulus, checked every cycle against an arithmetic model of the raster position.
`timescale 1ns/1ps
module tb_vid_timing_gen;

    localparam int PD = 2;
    localparam int LW = 4;
    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int XW = 4, YW = 3;
    localparam logic HPOL = 1'b0, VPOL = 1'b0;

    logic          clock = 1'b0;
    logic          reset_n, pll_locked;
    logic          run, pix_en, hsync, vsync, active, line_start, frame_start;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: lock history, lock streak, running flag, clocks since run began
    int m_s1 = 0, m_s2 = 0, streak = 0, t = 0;
    bit m_run = 1'b0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    vid_timing_gen #(
        .PIX_DIV(PD), .LOCK_WAIT(LW),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(0), .VS_POL(0), .X_W(XW), .Y_W(YW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .pll_locked(pll_locked),
        .run(run), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .active(active), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_pt();
        @(posedge clock);
        #2;
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return run;
            1:       return line_start;
            2:       return hsync;
            3:       return frame_start;
            default: return vsync;
        endcase
    endfunction

    task automatic wait_for(input string name, input int sel, input logic val,
                            input int budget, output int n);
        n = 0;
        while (sig(sel) != val && n < budget) begin
            cyc();
            n++;
        end
        if (sig(sel) != val) check(name, int'(sig(sel)), int'(val));
    endtask

    task automatic model_step();
        int lk;
        if (!reset_n) begin
            m_s1 = 0; m_s2 = 0; streak = 0; m_run = 1'b0; t = 0;
        end else begin
            lk = m_s2;
            streak = (lk != 0) ? streak + 1 : 0;
            if (m_run) begin
                if (lk == 0) m_run = 1'b0;
                else         t++;
            end else if (streak == LW) begin
                m_run = 1'b1;
                t = 0;
            end
            m_s2 = m_s1;
            m_s1 = int'(pll_locked);
        end
        chk_en = 1'b1;
    endtask

    task automatic compare();
        int d, p, ex, ey;
        bit hs_a, vs_a;
        d  = t % PD;
        p  = t / PD;
        ex = m_run ? p % HT : 0;
        ey = m_run ? (p / HT) % VT : 0;
        hs_a = m_run && ex >= HA + HF && ex < HA + HF + HS;
        vs_a = m_run && ey >= VA + VF && ey < VA + VF + VS;
        check("run", int'(run), int'(m_run));
        check("pix_en", int'(pix_en), int'(m_run && d == PD - 1));
        check("x", int'(x), ex);
        check("y", int'(y), ey);
        check("line_start", int'(line_start), int'(m_run && d == 0 && ex == 0));
        check("frame_start", int'(frame_start), int'(m_run && d == 0 && ex == 0 && ey == 0));
        check("active", int'(active), int'(m_run && ex < HA && ey < VA));
        check("hsync", int'(hsync), int'(hs_a ? HPOL : !HPOL));
        check("vsync", int'(vsync), int'(vs_a ? VPOL : !VPOL));
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) compare();
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        reset_n = 1'b0;
        pll_locked = 1'b0;
        repeat (3) cyc();
        check("rst_run", int'(run), 0);
        check("rst_hsync", int'(hsync), 1);
        check("rst_vsync", int'(vsync), 1);
        check("rst_x", int'(x), 0);
        check("rst_active", int'(active), 0);

        // startup with lock held
        pll_locked = 1'b1;
        drive_pt();
        reset_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (i == 5) check("s1_run_clk5", int'(run), 0);
        end
        check("s1_run_clk6", int'(run), 1);
        check("s1_frame_start", int'(frame_start), 1);
        check("s1_line_start", int'(line_start), 1);
        check("s1_x", int'(x), 0);
        check("s1_y", int'(y), 0);
        check("s1_pix_en_first", int'(pix_en), 0);
        cyc();
        check("s1_pix_en_second", int'(pix_en), 1);

        // line timing
        wait_for("s2_ls_a", 1, 1'b1, 100, n);
        cyc();
        wait_for("s2_ls_b", 1, 1'b1, 100, n);
        check("s2_line_period", n + 1, 28);
        wait_for("s2_hs_on", 2, HPOL, 100, n);
        check("s2_hs_x", int'(x), 10);
        n = 0;
        while (hsync == HPOL && n < 50) begin
            cyc();
            n++;
        end
        check("s2_hs_len", n, 4);
        check("s2_hs_end_x", int'(x), 12);

        // frame timing
        wait_for("s3_fs_a", 3, 1'b1, 400, n);
        cyc();
        wait_for("s3_fs_b", 3, 1'b1, 400, n);
        check("s3_frame_period", n + 1, 196);
        wait_for("s3_vs_on", 4, VPOL, 400, n);
        check("s3_vs_y", int'(y), 5);
        check("s3_vs_x", int'(x), 0);
        n = 0;
        while (vsync == VPOL && n < 100) begin
            cyc();
            n++;
        end
        check("s3_vs_len", n, 28);

        // lock loss mid-frame
        n = 0;
        while (!(x == 5 && y == 2) && n < 400) begin
            cyc();
            n++;
        end
        check("s5_reach_x", int'(x), 5);
        drive_pt();
        pll_locked = 1'b0;
        n = 0;
        do begin
            cyc();
            n++;
        end while (run && n < 20);
        check("s5_fall_delay", n, 3);
        check("s5_idle_hsync", int'(hsync), 1);
        check("s5_idle_x", int'(x), 0);
        repeat (5) cyc();
        drive_pt();
        pll_locked = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!run && n < 20);
        check("s5_rise_delay", n, 6);
        check("s5_frame_start", int'(frame_start), 1);
        check("s5_xy", int'(x) + int'(y), 0);

        // glitchy lock never qualifies
        drive_pt();
        pll_locked = 1'b0;
        repeat (5) drive_pt();
        pll_locked = 1'b1;
        repeat (3) drive_pt();
        pll_locked = 1'b0;
        drive_pt();
        pll_locked = 1'b1;
        repeat (3) drive_pt();
        pll_locked = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("s4_run", int'(run), 0);
            check("s4_hsync", int'(hsync), 1);
        end

        // reset while running
        drive_pt();
        pll_locked = 1'b1;
        @(negedge clock);
        wait_for("s6_run", 0, 1'b1, 20, n);
        n = 0;
        while (x != 3 && n < 100) begin
            cyc();
            n++;
        end
        drive_pt();
        reset_n = 1'b0;
        drive_pt();
        reset_n = 1'b1;
        check("s6_rst_run", int'(run), 0);
        check("s6_rst_x", int'(x), 0);
        check("s6_rst_hsync", int'(hsync), 1);
        check("s6_rst_line_start", int'(line_start), 0);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!run && n < 20);
        check("s6_restart_delay", n, 6);
        check("s6_frame_start", int'(frame_start), 1);

        // random lock and reset activity
        for (int s = 0; s < 40; s++) begin
            k = $urandom_range(0, 9);
            if (k == 0) begin
                drive_pt();
                reset_n = 1'b0;
                repeat ($urandom_range(1, 3)) drive_pt();
                reset_n = 1'b1;
            end else begin
                pll_locked = (k > 3);
                n = pll_locked ? $urandom_range(1, 300) : $urandom_range(1, 6);
                repeat (n) drive_pt();
            end
        end

        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
